// File: rtl/matmul_loop_ctrl.sv
// matmul_loop_ctrl
//
// Loop sequencer for the single-core matrix multiplier. It computes
// C[M x N] = A[M x P] * B[P x N] by walking the i/j/k index space, and for
// every output element it issues one accumulator clear, P multiply-accumulate
// steps and one result write.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   request a new multiply (honoured only while idle)
//   hold     in   stall; freezes sequencing while high during CLR/MAC/WB
//   dim_m    in   rows of A / C        (latched on accepted start)
//   dim_n    in   columns of B / C     (latched on accepted start)
//   dim_p    in   inner dimension      (latched on accepted start)
//   busy     out  high whenever the sequencer is not idle
//   done     out  one-cycle pulse at the end of a job
//   acc_clr  out  clear the accumulator
//   mac_en   out  accumulate A[addr_a] * B[addr_b] this cycle
//   c_we     out  write the accumulator to C[addr_c]
//   addr_a   out  A read address, row-major i*P + k
//   addr_b   out  B read address, row-major k*N + j
//   addr_c   out  C write address, row-major i*N + j
//
// Every output is a register. The registered state always names the step
// being presented this cycle; a hold sampled on an edge keeps that step's
// indices and addresses but drops its strobes, so the step is not repeated
// when sequencing resumes.

module matmul_loop_ctrl #(
    parameter int unsigned idx_width = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     hold,
    input  logic [idx_width-1:0]     dim_m,
    input  logic [idx_width-1:0]     dim_n,
    input  logic [idx_width-1:0]     dim_p,
    output logic                     busy,
    output logic                     done,
    output logic                     acc_clr,
    output logic                     mac_en,
    output logic                     c_we,
    output logic [2*idx_width-1:0]   addr_a,
    output logic [2*idx_width-1:0]   addr_b,
    output logic [2*idx_width-1:0]   addr_c
);

    localparam int unsigned AW = 2 * idx_width;
    localparam logic [idx_width-1:0] IDX_ONE = idx_width'(1);
    localparam logic [AW-1:0]        ADR_ONE = AW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_MAC,
        S_WB,
        S_DONE
    } state_t;

    state_t               state_q;

    // Latched job dimensions.
    logic [idx_width-1:0] m_q;
    logic [idx_width-1:0] n_q;
    logic [idx_width-1:0] p_q;

    // Loop indices of the step currently presented.
    logic [idx_width-1:0] i_q;
    logic [idx_width-1:0] j_q;
    logic [idx_width-1:0] k_q;

    // Running base i*P of the current A row.
    logic [AW-1:0]        row_a_q;

    // Registered outputs.
    logic                 busy_q;
    logic                 done_q;
    logic                 acc_clr_q;
    logic                 mac_en_q;
    logic                 c_we_q;
    logic [AW-1:0]        addr_a_q;
    logic [AW-1:0]        addr_b_q;
    logic [AW-1:0]        addr_c_q;

    // Zero-extended operands for the address adders.
    logic [AW-1:0]        n_ext;
    logic [AW-1:0]        p_ext;
    logic [AW-1:0]        j_ext;

    logic                 last_k;
    logic                 last_j;
    logic                 last_i;
    logic                 any_dim_zero;

    assign n_ext = {{idx_width{1'b0}}, n_q};
    assign p_ext = {{idx_width{1'b0}}, p_q};
    assign j_ext = {{idx_width{1'b0}}, j_q};

    // Dimensions are non-zero whenever these are consulted (CLR/MAC/WB only).
    assign last_k = (k_q == (p_q - IDX_ONE));
    assign last_j = (j_q == (n_q - IDX_ONE));
    assign last_i = (i_q == (m_q - IDX_ONE));

    assign any_dim_zero = (dim_m == '0) || (dim_n == '0) || (dim_p == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            n_q       <= '0;
            p_q       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            row_a_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            acc_clr_q <= 1'b0;
            mac_en_q  <= 1'b0;
            c_we_q    <= 1'b0;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            addr_c_q  <= '0;
        end else begin
            // Strobes are single-cycle; each branch re-asserts the one it needs.
            done_q    <= 1'b0;
            acc_clr_q <= 1'b0;
            mac_en_q  <= 1'b0;
            c_we_q    <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        m_q      <= dim_m;
                        n_q      <= dim_n;
                        p_q      <= dim_p;
                        i_q      <= '0;
                        j_q      <= '0;
                        k_q      <= '0;
                        row_a_q  <= '0;
                        addr_a_q <= '0;
                        addr_b_q <= '0;
                        addr_c_q <= '0;
                        busy_q   <= 1'b1;
                        if (any_dim_zero) begin
                            // Empty product: finish without touching the datapath.
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= S_CLR;
                            acc_clr_q <= 1'b1;
                        end
                    end
                end

                S_CLR: begin
                    if (!hold) begin
                        // Addresses were already set to (i*P, j) on entry to CLR.
                        state_q  <= S_MAC;
                        mac_en_q <= 1'b1;
                        k_q      <= '0;
                    end
                end

                S_MAC: begin
                    if (!hold) begin
                        if (last_k) begin
                            state_q <= S_WB;
                            c_we_q  <= 1'b1;
                            k_q     <= '0;
                        end else begin
                            mac_en_q <= 1'b1;
                            k_q      <= k_q + IDX_ONE;
                            addr_a_q <= addr_a_q + ADR_ONE;
                            addr_b_q <= addr_b_q + n_ext;
                        end
                    end
                end

                S_WB: begin
                    if (!hold) begin
                        if (last_i && last_j) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= S_CLR;
                            acc_clr_q <= 1'b1;
                            addr_c_q  <= addr_c_q + ADR_ONE;
                            if (last_j) begin
                                // Next row of C: advance the A row base by P.
                                j_q      <= '0;
                                i_q      <= i_q + IDX_ONE;
                                row_a_q  <= row_a_q + p_ext;
                                addr_a_q <= row_a_q + p_ext;
                                addr_b_q <= '0;
                            end else begin
                                j_q      <= j_q + IDX_ONE;
                                addr_a_q <= row_a_q;
                                addr_b_q <= j_ext + ADR_ONE;
                            end
                        end
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign acc_clr = acc_clr_q;
    assign mac_en  = mac_en_q;
    assign c_we    = c_we_q;
    assign addr_a  = addr_a_q;
    assign addr_b  = addr_b_q;
    assign addr_c  = addr_c_q;

endmodule

// File: tb/tb_matmul_loop_ctrl.sv
module tb_matmul_loop_ctrl;

    localparam int W  = 8;
    localparam int AW = 2 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          hold;
    logic [W-1:0]  dim_m;
    logic [W-1:0]  dim_n;
    logic [W-1:0]  dim_p;
    logic          busy;
    logic          done;
    logic          acc_clr;
    logic          mac_en;
    logic          c_we;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic [AW-1:0] addr_c;

    int checks   = 0;
    int failures = 0;

    matmul_loop_ctrl #(.idx_width(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .hold    (hold),
        .dim_m   (dim_m),
        .dim_n   (dim_n),
        .dim_p   (dim_p),
        .busy    (busy),
        .done    (done),
        .acc_clr (acc_clr),
        .mac_en  (mac_en),
        .c_we    (c_we),
        .addr_a  (addr_a),
        .addr_b  (addr_b),
        .addr_c  (addr_c)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: the job as an ordered list of datapath steps.
    typedef enum int {K_CLR, K_MAC, K_WB, K_DONE} kind_t;
    typedef struct {
        kind_t k;
        int    a;
        int    b;
        int    c;
    } step_t;

    task automatic check_idle(input string tag);
        check({tag, ".busy"},    busy,    0);
        check({tag, ".done"},    done,    0);
        check({tag, ".acc_clr"}, acc_clr, 0);
        check({tag, ".mac_en"},  mac_en,  0);
        check({tag, ".c_we"},    c_we,    0);
    endtask

    // hold_mode: 0 none, 1 random, 2 held during cycles 7..9 after start.
    // abort_wb > 0: assert rst during that WB and stop the job there.
    task automatic run_job(input int m, input int n, input int p,
                           input int hold_mode, input int abort_wb);
        step_t steps[$];
        step_t s;
        step_t cur;
        int    idx;
        int    cyc;
        int    holds;
        int    wbs;
        int    done_cyc;
        int    budget;
        bit    bubble;
        bit    hv;

        steps.delete();
        if (m > 0 && n > 0 && p > 0) begin
            for (int i = 0; i < m; i++) begin
                for (int j = 0; j < n; j++) begin
                    s.k = K_CLR; s.a = 0; s.b = 0; s.c = 0;
                    steps.push_back(s);
                    for (int k = 0; k < p; k++) begin
                        s.k = K_MAC; s.a = i * p + k; s.b = k * n + j; s.c = 0;
                        steps.push_back(s);
                    end
                    s.k = K_WB; s.a = 0; s.b = 0; s.c = i * n + j;
                    steps.push_back(s);
                end
            end
        end
        s.k = K_DONE; s.a = 0; s.b = 0; s.c = 0;
        steps.push_back(s);

        budget   = 4 * steps.size() + 100;
        holds    = 0;
        wbs      = 0;
        done_cyc = -1;

        @(posedge clk); #1;
        start = 1'b1;
        dim_m = W'(m);
        dim_n = W'(n);
        dim_p = W'(p);
        hold  = (hold_mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
        @(posedge clk);
        idx    = 0;
        cur    = steps[0];
        bubble = 0;
        cyc    = 1;
        #1;
        start = 1'b0;

        forever begin
            // Inputs for the edge that ends cycle cyc.
            case (hold_mode)
                1:       hv = (cyc < budget) && ($urandom_range(0, 3) == 0);
                2:       hv = (cyc >= 7 && cyc <= 9);
                default: hv = 1'b0;
            endcase
            hold = hv;
            // Start and dims wiggle while busy; none of it may be honoured.
            start = ($urandom_range(0, 3) == 0);
            dim_m = W'($urandom_range(0, 7));
            dim_n = W'($urandom_range(0, 7));
            dim_p = W'($urandom_range(0, 7));
            if (cur.k == K_WB && !bubble) begin
                wbs++;
                if (abort_wb > 0 && wbs == abort_wb) begin
                    rst   = 1'b1;
                    start = 1'b0;
                    hold  = 1'b0;
                end
            end

            @(negedge clk);
            check("busy",    busy,    1);
            check("done",    done,    cur.k == K_DONE);
            check("acc_clr", acc_clr, cur.k == K_CLR && !bubble);
            check("mac_en",  mac_en,  cur.k == K_MAC && !bubble);
            check("c_we",    c_we,    cur.k == K_WB  && !bubble);
            if (cur.k == K_MAC) begin
                check("addr_a", addr_a, cur.a);
                check("addr_b", addr_b, cur.b);
            end
            if (cur.k == K_WB)
                check("addr_c", addr_c, cur.c);
            if (cur.k == K_DONE)
                done_cyc = cyc;

            if (rst) begin
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                check_idle("rst");
                check("rst.addr_a", addr_a, 0);
                check("rst.addr_b", addr_b, 0);
                check("rst.addr_c", addr_c, 0);
                return;
            end

            @(posedge clk);
            cyc++;
            if (cur.k == K_DONE) begin
                break;
            end else if (hv) begin
                bubble = 1;
                holds++;
            end else begin
                idx++;
                cur    = steps[idx];
                bubble = 0;
            end
            #1;
        end

        // Back in IDLE with start low.
        #1;
        start = 1'b0;
        hold  = 1'b0;
        @(negedge clk);
        check_idle("idle");
        if (m > 0 && n > 0 && p > 0)
            check("done_cycle", done_cyc, m * n * (p + 2) + 1 + holds);
        else
            check("done_cycle", done_cyc, 1);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        hold  = 1'b0;
        dim_m = '0;
        dim_n = '0;
        dim_p = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_idle("reset");
        check("reset.addr_a", addr_a, 0);
        check("reset.addr_b", addr_b, 0);
        check("reset.addr_c", addr_c, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_job(1, 1, 1, 0, 0);
        run_job(2, 2, 2, 0, 0);
        run_job(3, 2, 0, 0, 0);
        run_job(2, 2, 2, 2, 0);
        run_job(1, 3, 5, 1, 0);
        for (int t = 0; t < 10; t++)
            run_job($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), 1, 0);
        run_job(4, 4, 4, 0, 3);
        run_job(1, 1, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
